// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU-to-SRAM bridge: one-hot state encoding,
// read-latency limit and the response-kind tags used to pick a read path.
package cpu_mem_pkg;

  // One-hot state encoding, matching the core's one-hot FSM style.
  typedef enum logic [5:0] {
    IDLE = 6'b000001,
    IRD  = 6'b000010,
    DRD  = 6'b000100,
    DWR  = 6'b001000,
    IRSP = 6'b010000,
    DRSP = 6'b100000
  } state_t;

  // Largest supported SRAM read latency; it fits the 3-bit latency counter.
  localparam int RD_LATENCY_MAX = 7;
  localparam int CTR_W          = 3;

  // Which channel a read belongs to.
  typedef enum logic {
    INST = 1'b0,
    DATA = 1'b1
  } resp_kind_t;

  // Read-issue state for a given response kind.
  function automatic state_t rd_state(input resp_kind_t kind);
    return (kind == DATA) ? DRD : IRD;
  endfunction

  // Response-holding state for a given response kind.
  function automatic state_t rsp_state(input resp_kind_t kind);
    return (kind == DATA) ? DRSP : IRSP;
  endfunction

endpackage

// File: rtl/cpu_mem_bridge_rd_latency_ctr.sv
// Loadable down-counter that times the SRAM read latency. done is high
// whenever the count is zero; the count holds at zero once it gets there.
module rd_latency_ctr
  import cpu_mem_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CTR_W-1:0] load_val,
  input  logic             dec,
  output logic             done
);

  logic [CTR_W-1:0] count_reg;
  logic [CTR_W-1:0] count_next;

  // Load has priority over decrement; decrement saturates at zero.
  always_comb begin
    count_next = count_reg;
    if (load) begin
      count_next = load_val;
    end else if (dec && (count_reg != '0)) begin
      count_next = count_reg - 1'b1;
    end
  end

  // Count register, cleared by the active-low synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign done = (count_reg == '0);

endmodule

// File: rtl/cpu_mem_bridge.sv
// Bridge between the multi-cycle MIPS core's fetch/data channels and a
// single synchronous SRAM port with fixed read latency. One request is
// served at a time; data requests win over fetches, and each read word is
// held in a response buffer until the core acknowledges it.
module cpu_mem_bridge
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       PC,
  input  logic              Inst_Req_Valid,
  output logic              Inst_Req_Ack,
  output logic [31:0]       Instruction,
  output logic              Inst_Valid,
  input  logic              Inst_Ack,
  input  logic [31:0]       Address,
  input  logic              MemWrite,
  input  logic [31:0]       Write_data,
  input  logic [3:0]        Write_strb,
  input  logic              MemRead,
  output logic              Mem_Req_Ack,
  output logic [31:0]       Read_data,
  output logic              Read_data_Valid,
  input  logic              Read_data_Ack,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_t            state_reg, state_next;
  logic [31:0]       buf_reg, buf_next;
  logic              mem_en_reg, mem_en_next;
  logic [3:0]        mem_we_reg, mem_we_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [31:0]       mem_wdata_reg, mem_wdata_next;
  logic              inst_req_ack, mem_req_ack;
  logic              ctr_load, ctr_dec, ctr_done;
  resp_kind_t        req_kind;

  // Byte-address bits outside the SRAM word range are intentionally ignored,
  // which also makes the SRAM address wrap modulo 2^ADDR_W.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{PC[31:ADDR_W+2], PC[1:0],
                              Address[31:ADDR_W+2], Address[1:0]};

  rd_latency_ctr u_rd_latency_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (ctr_load),
    .load_val (CTR_W'(RD_LATENCY)),
    .dec      (ctr_dec),
    .done     (ctr_done)
  );

  // The counter is loaded on read acceptance so it reaches zero exactly in
  // the cycle mem_rdata is valid, RD_LATENCY cycles after the enable cycle.
  assign ctr_dec = (state_reg == IRD) || (state_reg == DRD);

  // Next-state, arbitration and registered-output next values.
  always_comb begin
    state_next     = state_reg;
    buf_next       = buf_reg;
    mem_en_next    = 1'b0;
    mem_we_next    = 4'b0000;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    inst_req_ack   = 1'b0;
    mem_req_ack    = 1'b0;
    ctr_load       = 1'b0;
    req_kind       = MemRead ? DATA : INST;
    unique case (state_reg)
      IDLE: begin
        mem_req_ack  = MemRead | MemWrite;
        inst_req_ack = Inst_Req_Valid & ~MemRead & ~MemWrite;
        if (MemWrite) begin
          // A write wins over a simultaneous read; the read is dropped.
          state_next     = DWR;
          mem_en_next    = 1'b1;
          mem_we_next    = Write_strb;
          mem_addr_next  = Address[ADDR_W+1:2];
          mem_wdata_next = Write_data;
        end else if (MemRead || Inst_Req_Valid) begin
          state_next    = rd_state(req_kind);
          mem_en_next   = 1'b1;
          mem_addr_next = MemRead ? Address[ADDR_W+1:2] : PC[ADDR_W+1:2];
          ctr_load      = 1'b1;
          if (MemRead) begin
            mem_wdata_next = Write_data;
          end
        end
      end
      DWR: begin
        state_next = IDLE;
      end
      IRD, DRD: begin
        if (ctr_done) begin
          buf_next   = mem_rdata;
          state_next = rsp_state((state_reg == DRD) ? DATA : INST);
        end
      end
      IRSP: begin
        if (Inst_Ack) begin
          state_next = IDLE;
        end
      end
      DRSP: begin
        if (Read_data_Ack) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and registered outputs, with active-low synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      buf_reg       <= '0;
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 4'b0000;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      buf_reg       <= buf_next;
      mem_en_reg    <= mem_en_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
    end
  end

  // Simulation check: the core must not raise read and write together.
  always @(posedge clk) begin
    if (rst && (state_reg == IDLE)) begin
      assert (!(MemRead && MemWrite))
        else $error("cpu_mem_bridge: MemRead and MemWrite together, read dropped");
    end
  end

  assign Inst_Req_Ack    = inst_req_ack;
  assign Mem_Req_Ack     = mem_req_ack;
  assign Inst_Valid      = (state_reg == IRSP);
  assign Read_data_Valid = (state_reg == DRSP);
  assign Instruction     = buf_reg;
  assign Read_data       = buf_reg;
  assign mem_en          = mem_en_reg;
  assign mem_we          = mem_we_reg;
  assign mem_addr        = mem_addr_reg;
  assign mem_wdata       = mem_wdata_reg;

endmodule

// File: doc/cpu_mem_bridge.md
# cpu_mem_bridge

Single-port memory bridge placed directly downstream of the multi-cycle MIPS core. It terminates the core's four valid/ack channels: instruction request, instruction response, memory request and read-data response. It arbitrates them onto one synchronous SRAM port with a configurable fixed read latency, and buffers each read word until the core acknowledges it.

## Interface
Parameters:
- ADDR_W, 16: SRAM word-address width; byte address bits [ADDR_W+1:2] are used, all others ignored.
- RD_LATENCY, 1: cycles from an SRAM read-enable cycle to valid mem_rdata; legal range 1..7.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-low (rst==0 resets on the clock edge).
- PC  in  32  instruction byte address.
- Inst_Req_Valid  in  1  instruction fetch request.
- Inst_Req_Ack  out  1  fetch request accepted.
- Instruction  out  32  fetched word.
- Inst_Valid  out  1  Instruction is valid.
- Inst_Ack  in  1  core has taken Instruction.
- Address  in  32  data byte address, word-aligned.
- MemWrite  in  1  data write request.
- Write_data  in  32  write word, lanes pre-aligned by the core.
- Write_strb  in  4  byte enables; bit i enables Write_data[8i+7:8i].
- MemRead  in  1  data read request.
- Mem_Req_Ack  out  1  data request accepted.
- Read_data  out  32  read word.
- Read_data_Valid  out  1  Read_data is valid.
- Read_data_Ack  in  1  core has taken Read_data.
- mem_en  out  1  SRAM access enable.
- mem_we  out  4  SRAM byte write enables; non-zero only with mem_en.
- mem_addr  out  ADDR_W  SRAM word address.
- mem_wdata  out  32  SRAM write data.
- mem_rdata  in  32  SRAM read data.

## Operation
States: IDLE, IRD, DRD, DWR, IRSP, DRSP.
- IDLE: the bridge accepts at most one request per cycle.
  - Data has priority over instruction.
  - Mem_Req_Ack = (MemRead|MemWrite). Inst_Req_Ack = Inst_Req_Valid & ~MemRead & ~MemWrite. Both are combinational and are 0 outside IDLE.
  - On acceptance, the address, Write_data and Write_strb are registered.
  - Next state is DWR if MemWrite, DRD if MemRead, IRD if a fetch is accepted.
- MemWrite and MemRead high together: treated as a write; the read is dropped. An assertion fires in simulation.
- DWR: mem_en=1 and mem_we=strb for one cycle, then IDLE. A write has no response. Write_strb==0 still takes the DWR cycle with mem_we=0.
- IRD and DRD:
  - First cycle: mem_en=1 and mem_we=0, and a 3-bit counter loads RD_LATENCY.
  - The counter decrements each following cycle.
  - In the cycle the counter reaches 0, mem_rdata is captured into the response buffer and the state moves to IRSP or DRSP.
- IRSP: Inst_Valid=1 and Instruction=buffer. Leaves to IDLE on the cycle Inst_Ack=1.
- DRSP: Read_data_Valid=1 and Read_data=buffer. Leaves to IDLE on the cycle Read_data_Ack=1.
- Outputs are stable while Valid is high and the Ack is absent; the buffer is not overwritten.
- An Ack arriving while the matching Valid is low is ignored. The core's Inst_Ack in its INIT state therefore has no effect.
- Requests arriving outside IDLE are not acknowledged. The requester holds them per the valid/ack rule.
- mem_addr wraps modulo 2^ADDR_W with no error.

## Timing
- Reset (rst==0 at an edge) sets:
  - state=IDLE, counter=0, buffer=0.
  - Inst_Valid=0, Read_data_Valid=0, Instruction=0, Read_data=0.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Reset mid-transaction aborts it with no response. An SRAM read already issued is discarded.
- Ack outputs are combinational from state and requests. Valid and memory outputs are registered.
- Read latency, with acceptance at cycle T:
  - mem_en is high in T+1.
  - mem_rdata is sampled at the end of T+1+RD_LATENCY.
  - Valid rises in T+2+RD_LATENCY. For RD_LATENCY=1, Valid is high at T+3.
- Completing a read transaction with Ack in cycle R returns the bridge to IDLE in R+1, where a new request can be accepted. The minimum fetch-to-fetch interval is RD_LATENCY+3 cycles.
- Write: accepted at T, mem_we is high in T+1, and the bridge is in IDLE and able to accept at T+2.

## Structure
- Package cpu_mem_pkg holds:
  - the state encoding constants (one-hot, 6 bits, matching the core's one-hot style);
  - the RD_LATENCY limit constant;
  - the response-kind constants (INST, DATA).
- One sub-module, rd_latency_ctr: loadable 3-bit down-counter with a done flag. The FSM, arbitration and buffer stay in cpu_mem_bridge.

## Test plan
- Fetch with RD_LATENCY=1, SRAM word 0x10 preloaded with 0x2408_0005:
  - Drive PC=0x40 with Inst_Req_Valid.
  - Required: Inst_Req_Ack in T, mem_addr=0x10 and mem_en in T+1, Instruction=0x2408_0005 with Inst_Valid at T+3.
  - Hold Inst_Ack low for 4 cycles: Instruction stays stable.
- Byte write then read:
  - Write Address=0x100, Write_strb=4'b0010, Write_data=0x0000_AB00 over a word holding 0x1122_3344.
  - A following read returns Read_data=0x1122_AB44.
- Simultaneous requests: MemRead at 0x200 and Inst_Req_Valid in the same IDLE cycle.
  - Only Mem_Req_Ack rises.
  - The fetch is accepted only after Read_data_Ack completes the data read.
- Latency sweep: RD_LATENCY=1,3,7.
  - Valid rises exactly at T+2+RD_LATENCY in each case.
  - A spurious Read_data_Ack before Valid changes nothing.
- Reset mid-read: rst=0 during DRD.
  - All outputs take their reset values next cycle.
  - No Read_data_Valid appears afterwards, and the next request is accepted normally.
- Wrap: ADDR_W=16 with Address=0x0004_0008.
  - mem_addr=0x0002 and the access proceeds.
